// File: rtl/ga23_sdr_arbiter.sv
// GA23 tile-row fetch arbiter: latches per-layer tile requests, serialises them
// round-robin onto the single SDRAM tile port and returns each row to its layer.

module ga23_sdr_arbiter #(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_LAYERS-1:0]        layer_req,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    output logic [NUM_LAYERS*DATA_W-1:0] layer_data,
    output logic [NUM_LAYERS-1:0]        layer_rdy,
    output logic [NUM_LAYERS-1:0]        overrun,
    output logic [ADDR_W-1:0]            sdr_addr,
    output logic                         sdr_req,
    input  logic                         sdr_rdy,
    input  logic [DATA_W-1:0]            sdr_data
);

    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                  state_r;
    logic [NUM_LAYERS-1:0]   pending_r;
    logic [ADDR_W-1:0]       pend_addr_r [NUM_LAYERS];
    logic [IDX_W-1:0]        rr_ptr_r;
    logic [IDX_W-1:0]        cur_r;

    logic                    grant_valid_s;
    logic [IDX_W-1:0]        grant_idx_s;
    logic [NUM_LAYERS-1:0]   grant_oh_s;
    logic [IDX_W-1:0]        next_ptr_s;
    logic [IDX_W-1:0]        cand_idx_s;
    int                      cand_s;

    // Round-robin search: walk offsets downward so the smallest offset from rr_ptr wins.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = 0;
        cand_idx_s    = '0;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            cand_s = int'(rr_ptr_r) + k;
            if (cand_s >= NUM_LAYERS) begin
                cand_s = cand_s - NUM_LAYERS;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (pending_r[cand_idx_s]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = cand_idx_s;
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // One-hot view of the layer being granted this cycle (only meaningful in IDLE).
    always_comb begin
        grant_oh_s = '0;
        if ((state_r == ST_IDLE) && grant_valid_s) begin
            grant_oh_s[grant_idx_s] = 1'b1;
        end else begin
            grant_oh_s = '0;
        end
    end

    // Pointer advances to the layer after the one just served, wrapping at NUM_LAYERS.
    always_comb begin
        if (cur_r == IDX_W'(NUM_LAYERS - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = cur_r + IDX_W'(1);
        end
    end

    // Request capture, grant FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            pending_r  <= '0;
            rr_ptr_r   <= '0;
            cur_r      <= '0;
            layer_data <= '0;
            layer_rdy  <= '0;
            overrun    <= '0;
            sdr_addr   <= '0;
            sdr_req    <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                pend_addr_r[i] <= '0;
            end
        end else begin
            sdr_req   <= 1'b0;
            layer_rdy <= '0;

            // A re-request while granted keeps the new address pending; the grant
            // below reads the old latched address because this is a non-blocking update.
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (layer_req[i]) begin
                    pending_r[i]   <= 1'b1;
                    pend_addr_r[i] <= layer_addr[i*ADDR_W +: ADDR_W];
                    if (pending_r[i] && !grant_oh_s[i]) begin
                        overrun[i] <= 1'b1;
                    end
                end else if (grant_oh_s[i]) begin
                    pending_r[i] <= 1'b0;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        sdr_addr <= pend_addr_r[grant_idx_s];
                        sdr_req  <= 1'b1;
                        cur_r    <= grant_idx_s;
                        state_r  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (sdr_rdy) begin
                        layer_data[cur_r*DATA_W +: DATA_W] <= sdr_data;
                        layer_rdy[cur_r] <= 1'b1;
                        rr_ptr_r         <= next_ptr_s;
                        state_r          <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    ga23_sdr_arbiter_chk #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .layer_rdy (layer_rdy),
        .sdr_req   (sdr_req)
    );

endmodule

// Protocol invariants of the arbiter outputs.
module ga23_sdr_arbiter_chk #(
    parameter int NUM_LAYERS = 3
) (
    input logic                  clk,
    input logic                  reset_n,
    input logic [NUM_LAYERS-1:0] layer_rdy,
    input logic                  sdr_req
);

    // At most one layer is handed data per cycle.
    a_rdy_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(layer_rdy));

    // The controller request is a single-cycle pulse.
    a_req_pulse: assert property (@(posedge clk) disable iff (!reset_n)
        sdr_req |=> !sdr_req);

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Directed bench for ga23_sdr_arbiter with a hand-driven SDRAM controller.

module tb_ga23_sdr_arbiter;

    localparam int NL = 3;
    localparam int AW = 22;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NL-1:0]    layer_req;
    logic [NL*AW-1:0] layer_addr;
    logic [NL*DW-1:0] layer_data;
    logic [NL-1:0]    layer_rdy;
    logic [NL-1:0]    overrun;
    logic [AW-1:0]    sdr_addr;
    logic             sdr_req;
    logic             sdr_rdy;
    logic [DW-1:0]    sdr_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ga23_sdr_arbiter #(
        .NUM_LAYERS (NL),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .layer_req  (layer_req),
        .layer_addr (layer_addr),
        .layer_data (layer_data),
        .layer_rdy  (layer_rdy),
        .overrun    (overrun),
        .sdr_addr   (sdr_addr),
        .sdr_req    (sdr_req),
        .sdr_rdy    (sdr_rdy),
        .sdr_data   (sdr_data)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [NL-1:0] req, input logic [AW-1:0] a0,
                           input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        layer_req  = req;
        layer_addr = {a2, a1, a0};
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, layer_data, 0);
        check({tag, "_rdy"}, layer_rdy, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_saddr"}, sdr_addr, 0);
        check({tag, "_sreq"}, sdr_req, 0);
    endtask

    // Waits (bounded) for sdr_req, checks the address and the one-cycle pulse.
    task automatic expect_req(input string tag, input logic [AW-1:0] addr);
        int n = 0;
        while (sdr_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, sdr_req, 1);
        check({tag, "_addr"}, sdr_addr, addr);
        @(negedge clk);
        check({tag, "_pulse"}, sdr_req, 0);
        check({tag, "_hold"}, sdr_addr, addr);
    endtask

    // Controller answers after 'delay' cycles; checks the returned row and ready pulse.
    task automatic complete(input string tag, input int delay, input logic [DW-1:0] data,
                            input logic [NL-1:0] exp_rdy, input int slot);
        repeat (delay) @(negedge clk);
        sdr_rdy  = 1'b1;
        sdr_data = data;
        @(negedge clk);
        sdr_rdy  = 1'b0;
        sdr_data = '0;
        check({tag, "_rdy"}, layer_rdy, exp_rdy);
        check({tag, "_data"}, layer_data[slot*DW +: DW], data);
        @(negedge clk);
        check({tag, "_rdy_off"}, layer_rdy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        layer_req  = '0;
        layer_addr = '0;
        sdr_rdy    = 1'b0;
        sdr_data   = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check_zero("reset");

        // Single request from layer 1, sdr_req exactly two cycles later.
        set_req(3'b010, 22'h0, 22'h12345, 22'h0);
        @(negedge clk);
        set_req(3'b000, 22'h0, 22'h0, 22'h0);
        check("t1_early", sdr_req, 0);
        @(negedge clk);
        check("t1_lat", sdr_req, 1);
        expect_req("t1", 22'h12345);
        complete("t1", 4, 32'hDEADBEEF, 3'b010, 1);

        // Fresh reset so rr_ptr is 0, then all three layers at once.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_zero("rst2");
        set_req(3'b111, 22'h100, 22'h200, 22'h300);
        @(negedge clk);
        set_req(3'b000, 22'h0, 22'h0, 22'h0);
        expect_req("t2a", 22'h100);
        complete("t2a", 2, 32'hA0A0_0001, 3'b001, 0);
        expect_req("t2b", 22'h200);
        complete("t2b", 3, 32'hB0B0_0002, 3'b010, 1);
        expect_req("t2c", 22'h300);
        complete("t2c", 1, 32'hC0C0_0003, 3'b100, 2);
        check("t2_all", layer_data, {32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001});

        // Layer 0 completes (rr_ptr -> 1); then layers 0 and 2 pending: 2 first.
        set_req(3'b001, 22'h400, 22'h0, 22'h0);
        @(negedge clk);
        set_req(3'b000, 22'h0, 22'h0, 22'h0);
        expect_req("t3a", 22'h400);
        complete("t3a", 2, 32'h0000_0400, 3'b001, 0);
        set_req(3'b101, 22'h500, 22'h0, 22'h600);
        @(negedge clk);
        set_req(3'b000, 22'h0, 22'h0, 22'h0);
        expect_req("t3b", 22'h600);
        complete("t3b", 2, 32'h0000_0600, 3'b100, 2);
        expect_req("t3c", 22'h500);
        complete("t3c", 2, 32'h0000_0500, 3'b001, 0);

        // Overrun: layer 0 re-requests while waiting behind layer 1.
        set_req(3'b011, 22'h10, 22'h50, 22'h0);
        @(negedge clk);
        set_req(3'b000, 22'h0, 22'h0, 22'h0);
        expect_req("t4a", 22'h50);
        set_req(3'b001, 22'h20, 22'h0, 22'h0);
        @(negedge clk);
        set_req(3'b000, 22'h0, 22'h0, 22'h0);
        check("t4_ovr", overrun, 3'b001);
        complete("t4a", 2, 32'h0000_0050, 3'b010, 1);
        expect_req("t4b", 22'h20);
        complete("t4b", 2, 32'h0000_0020, 3'b001, 0);
        check("t4_ovr_sticky", overrun, 3'b001);

        // Same-cycle re-request on the grant cycle: old address first, no overrun.
        set_req(3'b100, 22'h0, 22'h0, 22'h30);
        @(negedge clk);
        set_req(3'b100, 22'h0, 22'h0, 22'h40);
        @(negedge clk);
        set_req(3'b000, 22'h0, 22'h0, 22'h0);
        expect_req("t5a", 22'h30);
        complete("t5a", 2, 32'h0000_0030, 3'b100, 2);
        expect_req("t5b", 22'h40);
        complete("t5b", 2, 32'h0000_0040, 3'b100, 2);
        check("t5_ovr", overrun, 3'b001);

        // Reset while in WAIT, then a stray sdr_rdy must be ignored.
        set_req(3'b010, 22'h0, 22'h77, 22'h0);
        @(negedge clk);
        set_req(3'b000, 22'h0, 22'h0, 22'h0);
        expect_req("t6a", 22'h77);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_zero("t6_rst");
        sdr_rdy  = 1'b1;
        sdr_data = 32'h0BAD_0BAD;
        @(negedge clk);
        sdr_rdy  = 1'b0;
        sdr_data = '0;
        check("t6_stray_rdy", layer_rdy, 0);
        check("t6_stray_data", layer_data, 0);
        @(negedge clk);
        check("t6_stray_req", sdr_req, 0);
        set_req(3'b001, 22'h99, 22'h0, 22'h0);
        @(negedge clk);
        set_req(3'b000, 22'h0, 22'h0, 22'h0);
        @(negedge clk);
        check("t6_lat", sdr_req, 1);
        expect_req("t6b", 22'h99);
        complete("t6b", 3, 32'h1234_5678, 3'b001, 0);
        check("t6_ovr", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
